// File: rtl/denise_pkg.sv
// Shared definitions for the Denise colour-table scheduler: the colour
// register window, the dump FSM states and the RAM word to RGB packing.
package denise_pkg;

    // Byte address of COLOR00; COLOR00..COLOR31 occupy 0x180..0x1BE.
    localparam logic [8:0] COLORBASE = 9'h180;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dump_state_t;

    // RAM word holds the high nibbles in [27:16] and the LOCT nibbles in [11:0];
    // interleave them into an 8-bit-per-gun RGB triple.
    function automatic logic [23:0] clut_pack(input logic [31:0] rd);
        logic [11:0] hi;
        logic [11:0] lo;
        hi = rd[27:16];
        lo = rd[11:0];
        return {hi[11:8], lo[11:8], hi[7:4], lo[7:4], hi[3:0], lo[3:0]};
    endfunction

endpackage

// File: rtl/denise_clut_dump_fifo.sv
// Two-entry {index, rgb} FIFO between RAM read capture and the output stream.
// Push and pop may happen in the same cycle even when full; flush empties it.
module denise_clut_dump_fifo (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        push,
    input  logic [7:0]  push_index,
    input  logic [23:0] push_rgb,
    input  logic        pop,
    output logic        not_empty,
    output logic [7:0]  head_index,
    output logic [23:0] head_rgb,
    output logic [1:0]  free
);

    logic [31:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        do_push;
    logic        do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    // Storage, pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= {push_index, push_rgb};
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign not_empty  = (count != 2'd0);
    assign head_index = mem[rd_ptr][31:24];
    assign head_rgb   = mem[rd_ptr][23:0];
    assign free       = 2'd2 - count;

endmodule

// File: rtl/denise_clut_scheduler.sv
// Arbitrates the Denise colour RAM between COLORxx register writes and a
// palette dump engine that reads entries back while the display is blanked.
//
// state | meaning
// IDLE  | no dump; waiting for dump_start
// ISSUE | issuing reads whenever blank, FIFO room and no RAW hazard allow
// DRAIN | all reads issued; waiting for FIFO and in-flight read to empty
// DONE  | one-cycle dump_done pulse, then back to IDLE
module denise_clut_scheduler
    import denise_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk7_en,
    input  logic [8:1]  reg_address_in,
    input  logic [11:0] data_in,
    input  logic [2:0]  bank,
    input  logic        loct,
    input  logic        blank,
    input  logic        dump_start,
    input  logic        dump_abort,
    input  logic [7:0]  dump_base,
    input  logic [7:0]  dump_count,
    output logic        dump_busy,
    output logic        dump_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_index,
    output logic [23:0] out_rgb,
    output logic        ram_wr_en,
    output logic [7:0]  ram_wr_adr,
    output logic [3:0]  ram_wr_be,
    output logic [31:0] ram_wr_dat,
    output logic        ram_rd_own,
    output logic [7:0]  ram_rd_adr,
    input  logic [31:0] ram_rd_dat
);

    dump_state_t state_q;
    dump_state_t state_d;
    logic [7:0]  addr_q;
    logic [7:0]  addr_d;
    logic [8:0]  remaining_q;
    logic [8:0]  remaining_d;
    logic        inflight_q;
    logic [7:0]  inflight_idx_q;
    logic        wr_dec;
    logic [7:0]  wr_adr_d;
    logic        raw_hazard;
    logic        issue;
    logic        fifo_valid;
    logic        fifo_pop;
    logic [1:0]  fifo_free;
    logic [2:0]  eff_free;
    logic        room;
    logic        unused_rd_bits;

    // Upper nibble of each 16-bit half carries no colour.
    assign unused_rd_bits = ^{ram_rd_dat[31:28], ram_rd_dat[15:12]};

    assign wr_dec   = clk7_en && (reg_address_in[8:6] == COLORBASE[8:6]);
    assign wr_adr_d = {bank, reg_address_in[5:1]};

    // Register-write stage; never stalled, independent of the dump engine.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_wr_en  <= 1'b0;
            ram_wr_adr <= 8'h00;
            ram_wr_be  <= 4'h0;
            ram_wr_dat <= 32'h0;
        end else begin
            ram_wr_en <= wr_dec;
            if (wr_dec) begin
                ram_wr_adr <= wr_adr_d;
                ram_wr_be  <= loct ? 4'b0011 : 4'b1111;
                ram_wr_dat <= {4'b0, data_in, 4'b0, data_in};
            end
        end
    end

    // A read must not overtake a write to the same entry that is decoded now
    // or still sitting in the write register.
    assign raw_hazard = (wr_dec && (wr_adr_d == addr_q)) ||
                        (ram_wr_en && (ram_wr_adr == addr_q));

    // A pop this cycle frees a slot in time for the read issued now, which
    // keeps one entry per clock flowing with only two FIFO slots.
    assign fifo_pop = fifo_valid && out_ready;
    assign eff_free = {1'b0, fifo_free} + {2'b00, fifo_pop};
    assign room     = eff_free > {2'b00, inflight_q};

    // Dump FSM state and read-pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= 8'h00;
            remaining_q <= 9'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
        end
    end

    // Next-state, read issue and pointer/count update; abort overrides all.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        issue       = 1'b0;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d     = ISSUE;
                    addr_d      = dump_base;
                    remaining_d = (dump_count == 8'd0) ? 9'd256 : {1'b0, dump_count};
                end
            end
            ISSUE: begin
                if (blank && room && !raw_hazard) begin
                    issue       = 1'b1;
                    addr_d      = addr_q + 8'd1;
                    remaining_d = remaining_q - 9'd1;
                    if (remaining_q == 9'd1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!fifo_valid && !inflight_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (dump_abort) begin
            state_d = IDLE;
            issue   = 1'b0;
        end
    end

    // Track the read issued last cycle so its data can be tagged on capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q     <= 1'b0;
            inflight_idx_q <= 8'h00;
        end else begin
            inflight_q <= issue && !dump_abort;
            if (issue) begin
                inflight_idx_q <= addr_q;
            end
        end
    end

    denise_clut_dump_fifo u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (dump_abort),
        .push       (inflight_q),
        .push_index (inflight_idx_q),
        .push_rgb   (clut_pack(ram_rd_dat)),
        .pop        (fifo_pop),
        .not_empty  (fifo_valid),
        .head_index (out_index),
        .head_rgb   (out_rgb),
        .free       (fifo_free)
    );

    assign out_valid  = fifo_valid;
    assign dump_busy  = (state_q == ISSUE) || (state_q == DRAIN);
    assign dump_done  = (state_q == DONE);
    assign ram_rd_own = issue;
    assign ram_rd_adr = addr_q;

endmodule

// File: tb/tb_denise_clut_scheduler.sv
// Bench for denise_clut_scheduler: table-driven write vectors, hand-written
// latency/RAW/abort/reset sequences and randomized dumps checked against a
// palette model built from the register writes the bench itself performs.
module tb_denise_clut_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk7_en = 1'b0;
    logic [7:0]  reg_address_in = 8'h00;
    logic [11:0] data_in = 12'h000;
    logic [2:0]  bank = 3'd0;
    logic        loct = 1'b0;
    logic        blank = 1'b0;
    logic        dump_start = 1'b0;
    logic        dump_abort = 1'b0;
    logic [7:0]  dump_base = 8'h00;
    logic [7:0]  dump_count = 8'h00;
    logic        dump_busy;
    logic        dump_done;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_index;
    logic [23:0] out_rgb;
    logic        ram_wr_en;
    logic [7:0]  ram_wr_adr;
    logic [3:0]  ram_wr_be;
    logic [31:0] ram_wr_dat;
    logic        ram_rd_own;
    logic [7:0]  ram_rd_adr;
    logic [31:0] ram_rd_dat = 32'h0;

    denise_clut_scheduler dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .clk7_en        (clk7_en),
        .reg_address_in (reg_address_in),
        .data_in        (data_in),
        .bank           (bank),
        .loct           (loct),
        .blank          (blank),
        .dump_start     (dump_start),
        .dump_abort     (dump_abort),
        .dump_base      (dump_base),
        .dump_count     (dump_count),
        .dump_busy      (dump_busy),
        .dump_done      (dump_done),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_index      (out_index),
        .out_rgb        (out_rgb),
        .ram_wr_en      (ram_wr_en),
        .ram_wr_adr     (ram_wr_adr),
        .ram_wr_be      (ram_wr_be),
        .ram_wr_dat     (ram_wr_dat),
        .ram_rd_own     (ram_rd_own),
        .ram_rd_adr     (ram_rd_adr),
        .ram_rd_dat     (ram_rd_dat)
    );

    always #18 clk = ~clk;

    // Colour RAM model: byte-enabled write port, 1-cycle read latency.
    logic [31:0] ram_mem [256];
    logic [31:0] ref_pal [256];
    logic        ram_load = 1'b0;

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= ref_pal[i];
        end else if (ram_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_wr_be[b]) ram_mem[ram_wr_adr][b*8 +: 8] <= ram_wr_dat[b*8 +: 8];
        end
        ram_rd_dat <= ram_mem[ram_rd_adr];
    end

    typedef struct packed {
        logic [7:0]  idx;
        logic [23:0] rgb;
    } ent_t;

    ent_t recv[$];
    int   done_cnt = 0;
    int   own_viol = 0;

    // Stream, done-pulse and read-port-ownership monitor, away from the edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && out_ready) recv.push_back({out_index, out_rgb});
            if (dump_done) done_cnt++;
            if (ram_rd_own && !blank) own_viol++;
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    logic rnd_ready = 1'b0;
    logic rnd_blank = 1'b0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        if (rnd_blank) blank = ($urandom_range(0, 99) < 70);
    endtask

    // Nibble-interleave of the two 12-bit colour halves of a RAM word.
    function automatic logic [23:0] pack_ref(input logic [31:0] w);
        int hi, lo, r;
        hi = int'(w >> 16) & 'hFFF;
        lo = int'(w) & 'hFFF;
        r = 0;
        for (int k = 2; k >= 0; k--)
            r = (r << 8) | (((hi >> (4 * k)) & 15) << 4) | ((lo >> (4 * k)) & 15);
        return r[23:0];
    endfunction

    // Palette model of one register write given as a byte address.
    task automatic model_write(input logic [8:0] a, input logic [11:0] d,
                               input logic [2:0] bk, input logic lc, input logic en);
        int idx;
        logic [31:0] w;
        if (en && a >= 9'h180 && a < 9'h1C0) begin
            idx = int'(bk) * 32 + (int'(a) - 'h180) / 2;
            w = {4'h0, d, 4'h0, d};
            if (lc) ref_pal[idx][15:0] = w[15:0];
            else    ref_pal[idx] = w;
        end
    endtask

    task automatic set_write(input logic [8:0] a, input logic [11:0] d,
                             input logic [2:0] bk, input logic lc, input logic en);
        reg_address_in = a[8:1];
        data_in        = d;
        bank           = bk;
        loct           = lc;
        clk7_en        = en;
        model_write(a, d, bk, lc, en);
    endtask

    task automatic wait_done(input int d0, input string name);
        int cyc = 0;
        while (done_cnt == d0 && cyc < 3000) begin
            tick();
            cyc++;
        end
        chk({name, "_done_seen"}, 96'(cyc < 3000), 96'd1);
    endtask

    task automatic compare_stream(input int rx0, input logic [7:0] base, input int n, input string name);
        int got;
        int idx;
        ent_t e;
        got = recv.size() - rx0;
        chk({name, "_count"}, 96'(got), 96'(n));
        for (int i = 0; i < n && i < got; i++) begin
            idx = (int'(base) + i) % 256;
            e.idx = 8'(idx);
            e.rgb = pack_ref(ref_pal[idx]);
            chk($sformatf("%s_entry%0d", name, i), 96'(recv[rx0 + i]), 96'(e));
        end
    endtask

    task automatic run_dump(input logic [7:0] base, input logic [7:0] cnt,
                            input logic rr, input logic rb, input string name);
        int n, rx0, d0, cyc;
        n = (cnt == 8'd0) ? 256 : int'(cnt);
        rx0 = recv.size();
        d0 = done_cnt;
        rnd_ready = rr;
        rnd_blank = rb;
        dump_base = base;
        dump_count = cnt;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        chk({name, "_busy"}, 96'(dump_busy), 96'd1);
        cyc = 0;
        while ((recv.size() - rx0 < n || done_cnt == d0) && cyc < 6000) begin
            tick();
            cyc++;
        end
        chk({name, "_in_time"}, 96'(cyc < 6000), 96'd1);
        repeat (4) tick();
        rnd_ready = 1'b0;
        rnd_blank = 1'b0;
        out_ready = 1'b1;
        blank = 1'b1;
        chk({name, "_done_once"}, 96'(done_cnt - d0), 96'd1);
        chk({name, "_idle_after"}, 96'(dump_busy), 96'd0);
        compare_stream(rx0, base, n, name);
    endtask

    typedef struct {
        logic [8:0]  addr;
        logic [11:0] data;
        logic [2:0]  bk;
        logic        lc;
        logic        en;
        logic        exp_en;
        logic [7:0]  exp_adr;
        logic [3:0]  exp_be;
        logic [31:0] exp_dat;
    } wvec_t;

    wvec_t wv[9];

    initial begin
        int rx0, d0;
        logic [95:0] all_out;

        wv[0] = '{9'h186, 12'hABC, 3'd2, 1'b0, 1'b1, 1'b1, 8'h43, 4'hF, 32'h0ABC0ABC};
        wv[1] = '{9'h186, 12'hABC, 3'd2, 1'b1, 1'b1, 1'b1, 8'h43, 4'h3, 32'h0ABC0ABC};
        wv[2] = '{9'h186, 12'h123, 3'd2, 1'b1, 1'b1, 1'b1, 8'h43, 4'h3, 32'h01230123};
        wv[3] = '{9'h180, 12'h5A5, 3'd0, 1'b0, 1'b1, 1'b1, 8'h00, 4'hF, 32'h05A505A5};
        wv[4] = '{9'h1BE, 12'hFED, 3'd7, 1'b0, 1'b1, 1'b1, 8'hFF, 4'hF, 32'h0FED0FED};
        wv[5] = '{9'h1A2, 12'h333, 3'd5, 1'b0, 1'b1, 1'b1, 8'hB1, 4'hF, 32'h03330333};
        wv[6] = '{9'h18A, 12'h777, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0};
        wv[7] = '{9'h100, 12'h111, 3'd1, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 32'h0};
        wv[8] = '{9'h1C0, 12'h222, 3'd1, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 32'h0};

        for (int i = 0; i < 256; i++) ref_pal[i] = $urandom;

        reset_n = 1'b0;
        ram_load = 1'b1;
        tick();
        ram_load = 1'b0;
        tick();
        all_out = {dump_busy, dump_done, out_valid, out_index, out_rgb, ram_wr_en,
                   ram_wr_adr, ram_wr_be, ram_wr_dat, ram_rd_own, ram_rd_adr};
        chk("reset_outputs", all_out, 96'd0);
        reset_n = 1'b1;
        tick();

        // Write-path vectors.
        for (int i = 0; i < 9; i++) begin
            set_write(wv[i].addr, wv[i].data, wv[i].bk, wv[i].lc, wv[i].en);
            tick();
            clk7_en = 1'b0;
            chk($sformatf("wr%0d_en", i), 96'(ram_wr_en), 96'(wv[i].exp_en));
            if (wv[i].exp_en) begin
                chk($sformatf("wr%0d_adr", i), 96'(ram_wr_adr), 96'(wv[i].exp_adr));
                chk($sformatf("wr%0d_be", i), 96'(ram_wr_be), 96'(wv[i].exp_be));
                chk($sformatf("wr%0d_dat", i), 96'(ram_wr_dat), 96'(wv[i].exp_dat));
            end
            tick();
            chk($sformatf("wr%0d_en_one_clk", i), 96'(ram_wr_en), 96'd0);
        end

        // LOCT readback and start-to-first-valid latency.
        blank = 1'b1;
        out_ready = 1'b1;
        d0 = done_cnt;
        dump_base = 8'h43;
        dump_count = 8'd1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        chk("lat_busy", 96'(dump_busy), 96'd1);
        chk("lat_valid_c1", 96'(out_valid), 96'd0);
        tick();
        chk("lat_valid_c2", 96'(out_valid), 96'd0);
        tick();
        chk("lat_valid_c3", 96'(out_valid), 96'd1);
        chk("loct_index", 96'(out_index), 96'h43);
        chk("loct_rgb", 96'(out_rgb), 96'hA1B2C3);
        wait_done(d0, "loct");
        chk("loct_done_once", 96'(done_cnt - d0), 96'd1);

        // Wrap-around dump.
        run_dump(8'hFE, 8'd4, 1'b0, 1'b0, "wrap");

        // RAW hazard: COLOR05 written in the cycle index 5 would be read.
        rx0 = recv.size();
        d0 = done_cnt;
        dump_base = 8'h00;
        dump_count = 8'd16;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        repeat (5) tick();
        set_write(9'h18A, 12'h9E1, 3'd0, 1'b0, 1'b1);
        #1;
        chk("raw_stall_decode", 96'(ram_rd_own), 96'd0);
        tick();
        clk7_en = 1'b0;
        chk("raw_stall_reg", 96'(ram_rd_own), 96'd0);
        tick();
        chk("raw_issue_own", 96'(ram_rd_own), 96'd1);
        chk("raw_issue_adr", 96'(ram_rd_adr), 96'd5);
        wait_done(d0, "raw");
        compare_stream(rx0, 8'h00, 16, "raw");

        // Abort mid-dump with the FIFO holding data.
        rx0 = recv.size();
        d0 = done_cnt;
        out_ready = 1'b0;
        dump_base = 8'h20;
        dump_count = 8'd40;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        repeat (4) tick();
        chk("abort_pre_valid", 96'(out_valid), 96'd1);
        dump_abort = 1'b1;
        tick();
        dump_abort = 1'b0;
        chk("abort_busy", 96'(dump_busy), 96'd0);
        chk("abort_valid", 96'(out_valid), 96'd0);
        out_ready = 1'b1;
        repeat (6) tick();
        chk("abort_no_done", 96'(done_cnt - d0), 96'd0);
        chk("abort_no_output", 96'(recv.size() - rx0), 96'd0);

        // Start and abort together: abort wins.
        dump_start = 1'b1;
        dump_abort = 1'b1;
        tick();
        dump_start = 1'b0;
        dump_abort = 1'b0;
        chk("start_abort_busy", 96'(dump_busy), 96'd0);
        tick();
        chk("start_abort_own", 96'(ram_rd_own), 96'd0);

        // Randomized dumps with backpressure and blank gating, incl. count 0.
        run_dump(8'($urandom), 8'd0, 1'b1, 1'b1, "rnd_full");
        for (int r = 0; r < 4; r++)
            run_dump(8'($urandom), 8'($urandom_range(1, 40)), 1'b1, 1'b1, $sformatf("rnd%0d", r));
        chk("own_while_unblanked", 96'(own_viol), 96'd0);

        // Asynchronous reset in the middle of a dump.
        dump_base = 8'h80;
        dump_count = 8'd100;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        repeat (5) tick();
        chk("pre_reset_busy", 96'(dump_busy), 96'd1);
        #5;
        reset_n = 1'b0;
        #1;
        all_out = {dump_busy, dump_done, out_valid, out_index, out_rgb, ram_wr_en,
                   ram_wr_adr, ram_wr_be, ram_wr_dat, ram_rd_own, ram_rd_adr};
        chk("async_reset_outputs", all_out, 96'd0);
        tick();
        reset_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
